// File: rtl/instruction_fetch_pkg.sv
// Shared CPU definitions: datapath widths, fetch FSM encoding, counter helper.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package instruction_fetch_pkg;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 32;
  localparam int COUNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] value);
    return (&value) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/instruction_fetch_program_counter.sv
// Program counter: loadable 8-bit counter, load wins over increment, wraps 255->0.
// Latency: new value visible one clock after load/increment.
// Backpressure: none; the caller only pulses increment when a fetch is accepted.
module program_counter
  import instruction_fetch_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_value,
  input  logic              increment,
  output logic [ADDR_W-1:0] count
);

  // Redirect has priority; otherwise step by one with natural modulo-256 wrap.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (increment) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: IDLE/RUN/HALT sequencer feeding a one-entry IR to the decoder.
// Latency: one cycle from enable to first fetch; one bubble after every jump.
// Backpressure: IR holds and PC stalls while ir_valid && !ir_ready; jumps flush regardless.
module instruction_fetch
  import instruction_fetch_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               halt_request,
  input  logic               jump_valid,
  input  logic [ADDR_W-1:0]  jump_target,
  output logic [ADDR_W-1:0]  imem_address,
  input  logic [INSTR_W-1:0] imem_instruction,
  output logic [INSTR_W-1:0] ir_instruction,
  output logic [ADDR_W-1:0]  ir_address,
  output logic               ir_valid,
  input  logic               ir_ready,
  output logic [COUNT_W-1:0] fetch_count,
  output logic               running
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic              fetch;

  // A fetch needs RUN, permission, no stop/redirect, and room in the IR.
  assign fetch = (state == RUN) && enable && !halt_request && !jump_valid &&
                 (!ir_valid || ir_ready);

  assign imem_address = pc;

  program_counter u_pc (
    .clock      (clock),
    .reset      (reset),
    .load       (jump_valid),
    .load_value (jump_target),
    .increment  (fetch),
    .count      (pc)
  );

  // Sequencer: enable=0 beats everything in RUN, a jump beats halt, HALT exits only on a jump.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      running <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable && !jump_valid) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          if (!enable) begin
            state   <= IDLE;
            running <= 1'b0;
          end else if (halt_request && !jump_valid) begin
            state   <= HALT;
            running <= 1'b0;
          end
        end
        HALT: begin
          if (jump_valid) begin
            state   <= enable ? RUN : IDLE;
            running <= enable;
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

  // IR: a jump flushes, a fetch loads, a consumed entry without refill empties; data is kept.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ir_valid       <= 1'b0;
      ir_instruction <= '0;
      ir_address     <= '0;
    end else if (jump_valid) begin
      ir_valid <= 1'b0;
    end else if (fetch) begin
      ir_valid       <= 1'b1;
      ir_instruction <= imem_instruction;
      ir_address     <= pc;
    end else if (ir_valid && ir_ready) begin
      ir_valid <= 1'b0;
    end
  end

  // Count IR loads, sticking at the maximum.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_count <= '0;
    end else if (fetch) begin
      fetch_count <= sat_inc(fetch_count);
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        halt_request;
  logic        jump_valid;
  logic [7:0]  jump_target;
  logic [7:0]  imem_address;
  logic [31:0] imem_instruction;
  logic [31:0] ir_instruction;
  logic [7:0]  ir_address;
  logic        ir_valid;
  logic        ir_ready;
  logic [15:0] fetch_count;
  logic        running;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  bit         sb_on = 1'b0;

  instruction_fetch dut (
    .clock            (clock),
    .reset            (reset),
    .enable           (enable),
    .halt_request     (halt_request),
    .jump_valid       (jump_valid),
    .jump_target      (jump_target),
    .imem_address     (imem_address),
    .imem_instruction (imem_instruction),
    .ir_instruction   (ir_instruction),
    .ir_address       (ir_address),
    .ir_valid         (ir_valid),
    .ir_ready         (ir_ready),
    .fetch_count      (fetch_count),
    .running          (running)
  );

  always #5 clock = ~clock;

  // Instruction memory model: word = A0000000 + address.
  assign imem_instruction = 32'hA000_0000 + {24'd0, imem_address};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push_range(input logic [7:0] lo, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(lo + 8'(k));
  endtask

  task automatic wait_addr(input logic [7:0] a);
    int i;
    for (i = 0; i < 40; i++) begin
      if (ir_valid && ir_address == a) break;
      step(1);
    end
    chk($sformatf("wait_addr_%0d", a), 32'(ir_valid && ir_address == a), 32'd1);
  endtask

  // Scoreboard: every decoder transfer must match the next expected address.
  always @(negedge clock) begin
    if (sb_on && !reset && ir_valid && ir_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        logic [7:0] a;
        a = exp_q.pop_front();
        chk("sb_addr", 32'(ir_address), 32'(a));
        chk("sb_instr", ir_instruction, 32'hA000_0000 + 32'(a));
      end
    end
  end

  initial begin
    reset = 1'b1; enable = 1'b0; halt_request = 1'b0; jump_valid = 1'b0;
    jump_target = 8'd0; ir_ready = 1'b0;
    #3;
    chk("rst_valid", 32'(ir_valid), 32'd0);
    chk("rst_imem", 32'(imem_address), 32'd0);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_count", 32'(fetch_count), 32'd0);
    chk("rst_instr", ir_instruction, 32'd0);
    step(2);
    reset = 1'b0;
    step(1);
    chk("idle_running", 32'(running), 32'd0);

    // Streaming fetch with start latency.
    sb_on = 1'b1;
    push_range(8'd0, 11);
    enable = 1'b1; ir_ready = 1'b1;
    step(1);
    chk("start_running", 32'(running), 32'd1);
    chk("start_no_fetch", 32'(ir_valid), 32'd0);
    step(1);
    chk("first_valid", 32'(ir_valid), 32'd1);
    chk("first_addr", 32'(ir_address), 32'd0);

    // Decoder stall at address 5.
    wait_addr(8'd5);
    ir_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step(1);
      chk("stall_addr", 32'(ir_address), 32'd5);
      chk("stall_instr", ir_instruction, 32'hA000_0005);
      chk("stall_pc", 32'(imem_address), 32'd6);
      chk("stall_count", 32'(fetch_count), 32'd6);
    end
    ir_ready = 1'b1;
    step(1);
    chk("resume_addr", 32'(ir_address), 32'd6);

    // Jump to 200 with one bubble.
    wait_addr(8'd10);
    jump_valid = 1'b1; jump_target = 8'd200;
    push_range(8'd200, 4);
    step(1);
    chk("jump_bubble", 32'(ir_valid), 32'd0);
    chk("jump_pc", 32'(imem_address), 32'd200);
    jump_valid = 1'b0;
    step(1);
    chk("jump_valid", 32'(ir_valid), 32'd1);
    chk("jump_addr", 32'(ir_address), 32'd200);

    // Jump to 254 and wrap through 255 -> 0.
    wait_addr(8'd203);
    jump_valid = 1'b1; jump_target = 8'd254;
    push_range(8'd254, 4);
    step(1);
    chk("jump2_bubble", 32'(ir_valid), 32'd0);
    jump_valid = 1'b0;
    wait_addr(8'd1);

    // Halt: no more fetches, held instruction drains.
    ir_ready = 1'b0; halt_request = 1'b1;
    step(1);
    chk("halt_running", 32'(running), 32'd0);
    chk("halt_hold", 32'(ir_valid), 32'd1);
    chk("halt_pc", 32'(imem_address), 32'd2);
    halt_request = 1'b0; ir_ready = 1'b1;
    step(1);
    chk("halt_drain", 32'(ir_valid), 32'd0);
    step(2);
    chk("halt_nofetch", 32'(ir_valid), 32'd0);
    chk("halt_count", 32'(fetch_count), 32'd19);
    chk("halt_pc2", 32'(imem_address), 32'd2);

    // Jump out of HALT to 3.
    jump_valid = 1'b1; jump_target = 8'd3;
    push_range(8'd3, 1);
    step(1);
    chk("resume_running", 32'(running), 32'd1);
    chk("resume_bubble", 32'(ir_valid), 32'd0);
    jump_valid = 1'b0;
    step(1);
    chk("resume3_valid", 32'(ir_valid), 32'd1);
    chk("resume3_addr", 32'(ir_address), 32'd3);

    // Park a stalled instruction at 76 (PC=77), then reset mid-cycle.
    jump_valid = 1'b1; jump_target = 8'd76;
    step(1);
    jump_valid = 1'b0; ir_ready = 1'b0;
    step(1);
    chk("pre_rst_valid", 32'(ir_valid), 32'd1);
    chk("pre_rst_pc", 32'(imem_address), 32'd77);
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", 32'(ir_valid), 32'd0);
    chk("arst_addr", 32'(ir_address), 32'd0);
    chk("arst_instr", ir_instruction, 32'd0);
    chk("arst_imem", 32'(imem_address), 32'd0);
    chk("arst_running", 32'(running), 32'd0);
    chk("arst_count", 32'(fetch_count), 32'd0);
    chk("sb_drain1", 32'(exp_q.size()), 32'd0);
    step(1);
    reset = 1'b0; ir_ready = 1'b1;
    push_range(8'd0, 1);
    step(1);
    chk("post_rst_latency", 32'(ir_valid), 32'd0);
    step(1);
    chk("post_rst_addr", 32'(ir_address), 32'd0);
    chk("post_rst_valid", 32'(ir_valid), 32'd1);
    step(1);
    chk("sb_drain2", 32'(exp_q.size()), 32'd0);
    sb_on = 1'b0;

    // Fetch counter saturation.
    for (int i = 0; i < 70000 && fetch_count != 16'd65534; i++) step(1);
    chk("cnt_reach", 32'(fetch_count), 32'd65534);
    step(1);
    chk("cnt_max", 32'(fetch_count), 32'd65535);
    step(3);
    chk("cnt_sat", 32'(fetch_count), 32'd65535);
    chk("cnt_still_fetching", 32'(ir_valid), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
